// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between a FIFO-buffered LPC host byte stream and a local byte source.
// Build option UART_TX_ARB_LOCAL_EN enables the local source; without it only the host FIFO is serviced.
module uart_tx_arbiter #(
  parameter int DEPTH_LOG2  = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       lpc_clk,
  input  logic       lpc_rst,
  input  logic [7:0] host_data,
  input  logic       host_in,
  input  logic [7:0] loc_data,
  input  logic       loc_valid,
  output logic       loc_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic       grant_host
);
  // state  | meaning
  // S_IDLE | UART free check, arbitrate and launch
  // S_ACK  | launch issued, waiting for tx_busy or timeout
  // S_DONE | UART transmitting, waiting for tx_busy to fall
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_DONE} state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [7:0] TO_LOAD = 8'(ACK_TIMEOUT - 1);

  state_t state, state_nxt;

  logic                  host_in_q, host_in_qq;
  logic [7:0]            host_data_q;
  logic [7:0]            fifo_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   fifo_cnt, fifo_cnt_nxt;
  logic [7:0]            to_cnt;
  logic                  push_req, push, pop, drop, full;
  logic                  host_pend, loc_pend, host_win, loc_win, launch;
  logic [7:0]            launch_data;

`ifdef UART_TX_ARB_LOCAL_EN
  assign loc_pend    = loc_valid;
  assign launch_data = host_win ? fifo_mem[rd_ptr] : loc_data;
`else
  logic [8:0] unused_loc;
  assign unused_loc  = {loc_valid, loc_data};
  assign loc_pend    = 1'b0;
  assign launch_data = fifo_mem[rd_ptr];
`endif

  assign full      = (fifo_cnt == FULL_CNT);
  assign host_pend = (fifo_cnt != '0);
  assign push_req  = host_in_q & ~host_in_qq;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign pop       = host_win;
  assign launch    = host_win | loc_win;
  assign loc_ready = loc_win;

  always_comb begin
    state_nxt = state;
    host_win  = 1'b0;
    loc_win   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!tx_busy) begin
          // grant_host holds the previous winner, so a tie goes to the other source
          host_win = host_pend && (!loc_pend || !grant_host);
          loc_win  = loc_pend && !host_win;
          if (host_win || loc_win) state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (tx_busy) state_nxt = S_DONE;
        else if (to_cnt == 8'd0) state_nxt = S_IDLE;
      end
      S_DONE: begin
        if (!tx_busy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    if (push && !pop) fifo_cnt_nxt = fifo_cnt + 1'b1;
    else if (pop && !push) fifo_cnt_nxt = fifo_cnt - 1'b1;
  end

  always_ff @(posedge lpc_clk) begin
    if (push) fifo_mem[wr_ptr] <= host_data_q;
  end

  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      host_in_q   <= 1'b0;
      host_in_qq  <= 1'b0;
      host_data_q <= 8'd0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      busy        <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      host_in_q   <= host_in;
      host_in_qq  <= host_in_q;
      host_data_q <= host_data;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt_nxt;
      busy     <= (fifo_cnt_nxt == FULL_CNT);
      if (drop) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      state      <= S_IDLE;
      to_cnt     <= 8'd0;
      tx_start   <= 1'b0;
      tx_data    <= 8'd0;
      grant_host <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_start <= launch;
      if (launch) begin
        tx_data    <= launch_data;
        grant_host <= host_win;
        to_cnt     <= TO_LOAD;
      end else if (state == S_ACK && to_cnt != 8'd0) begin
        to_cnt <= to_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a launch scoreboard and a simple UART busy responder.
module tb_uart_tx_arbiter;
  logic       lpc_clk = 1'b0;
  logic       lpc_rst = 1'b0;
  logic [7:0] host_data = 8'd0;
  logic       host_in = 1'b0;
  logic [7:0] loc_data = 8'd0;
  logic       loc_valid = 1'b0;
  logic       loc_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic       ovf;
  logic       ovf_clr = 1'b0;
  logic       grant_host;

  logic hold_busy = 1'b0;
  logic resp_busy = 1'b0;
  logic resp_en   = 1'b1;
  int   resp_cnt  = 0;
  assign tx_busy = hold_busy | resp_busy;

  typedef struct {
    logic [7:0] d;
    logic       h;
  } exp_t;
  exp_t exp_q[$];
  int   launch_cyc_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_launch = 0;
  int n_loc_acc = 0;
  int locrdy_seen = 0;
  logic prev_start = 1'b0;

  uart_tx_arbiter #(.DEPTH_LOG2(2), .ACK_TIMEOUT(15)) dut (
    .lpc_clk(lpc_clk), .lpc_rst(lpc_rst), .host_data(host_data), .host_in(host_in),
    .loc_data(loc_data), .loc_valid(loc_valid), .loc_ready(loc_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy),
    .ovf(ovf), .ovf_clr(ovf_clr), .grant_host(grant_host)
  );

  always #5 lpc_clk = ~lpc_clk;
  always @(posedge lpc_clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
    end
  endtask

  always @(negedge lpc_clk) begin
    if (resp_en && tx_start) resp_cnt = 3;
    else if (resp_cnt > 0) resp_cnt--;
    resp_busy = (resp_cnt > 0);
  end

  always @(negedge lpc_clk) begin
    exp_t e;
    if (loc_ready) locrdy_seen++;
    if (loc_valid && loc_ready) n_loc_acc++;
    if (tx_start) begin
      chk("tx_start_one_clock", {31'd0, prev_start}, 32'd0);
      n_launch++;
      launch_cyc_q.push_back(cyc);
      chk("launch_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_data", {24'd0, tx_data}, {24'd0, e.d});
        chk("grant_host", {31'd0, grant_host}, {31'd0, e.h});
      end
    end
    prev_start = tx_start;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge lpc_clk);
      #1;
    end
  endtask

  task automatic host_write(input logic [7:0] d);
    host_data = d;
    host_in   = 1'b1;
    tick(2);
    host_in = 1'b0;
    tick(2);
  endtask

  task automatic exp_push(input logic [7:0] d, input logic h);
    exp_t e;
    e.d = d;
    e.h = h;
    exp_q.push_back(e);
  endtask

  task automatic wait_launches(input int target, input int max_cyc, input string tag);
    int c = 0;
    while (n_launch < target && c < max_cyc) begin
      tick(1);
      c++;
    end
    chk(tag, n_launch, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_loc_ready"}, {31'd0, loc_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    chk({tag, "_grant_host"}, {31'd0, grant_host}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, base, n, c;

    tick(2);
    check_reset_outputs("reset");
    lpc_rst = 1'b1;
    tick(2);

    // single host byte, level held for 4 clocks
    exp_push(8'h41, 1'b1);
    c0 = cyc;
    host_data = 8'h41;
    host_in   = 1'b1;
    tick(4);
    host_in = 1'b0;
    wait_launches(1, 50, "host_single_launch");
    tick(20);
    chk("host_no_duplicate", n_launch, 1);
    if (launch_cyc_q.size() > 0) chk("host_latency", launch_cyc_q[0] - c0, 3);
    chk("host_tx_data_held", {24'd0, tx_data}, 32'h41);

    // fill FIFO while UART busy, overflow on the fifth
    hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) host_write(8'h10 + 8'(i));
    chk("busy_three_entries", {31'd0, busy}, 32'd0);
    host_write(8'h13);
    chk("busy_full", {31'd0, busy}, 32'd1);
    chk("ovf_before_drop", {31'd0, ovf}, 32'd0);
    host_write(8'h14);
    chk("ovf_after_drop", {31'd0, ovf}, 32'd1);
    chk("no_launch_while_busy", n_launch, 1);
    for (int i = 0; i < 4; i++) exp_push(8'h10 + 8'(i), 1'b1);
    hold_busy = 1'b0;
    wait_launches(5, 200, "fifo_drain_launches");
    tick(2);
    chk("busy_after_drain", {31'd0, busy}, 32'd0);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(1);
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);

    // reset while in DONE with bytes queued
    resp_en = 1'b0;
    exp_push(8'hC0, 1'b1);
    host_write(8'hC0);
    wait_launches(6, 50, "done_launch");
    hold_busy = 1'b1;
    for (int i = 1; i < 4; i++) host_write(8'hC0 + 8'(i));
    chk("done_no_extra_launch", n_launch, 6);
    lpc_rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick(3);
    lpc_rst   = 1'b1;
    hold_busy = 1'b0;
    resp_en   = 1'b1;
    tick(40);
    chk("no_launch_after_reset", n_launch, 6);
    chk("scoreboard_empty_after_reset", exp_q.size(), 0);

    // arbitration from reset: host wins first tie
    locrdy_seen = 0;
    base = n_launch;
`ifdef UART_TX_ARB_LOCAL_EN
    hold_busy = 1'b1;
    host_write(8'hA0);
    host_write(8'hA1);
    loc_data  = 8'h55;
    loc_valid = 1'b1;
    exp_push(8'hA0, 1'b1);
    exp_push(8'h55, 1'b0);
    exp_push(8'hA1, 1'b1);
    hold_busy = 1'b0;
    c = 0;
    while (n_loc_acc < 1 && c < 100) begin
      tick(1);
      c++;
    end
    loc_valid = 1'b0;
    chk("local_accepted_once", n_loc_acc, 1);
    wait_launches(base + 3, 200, "rr_launches");
`else
    loc_data  = 8'h55;
    loc_valid = 1'b1;
    exp_push(8'hA0, 1'b1);
    exp_push(8'hA1, 1'b1);
    host_write(8'hA0);
    host_write(8'hA1);
    wait_launches(base + 2, 200, "host_only_launches");
    tick(10);
    chk("loc_ready_never", locrdy_seen, 0);
    chk("host_only_count", n_launch, base + 2);
    loc_valid = 1'b0;
`endif

    // UART never acknowledges: timeout then next byte
    resp_en = 1'b0;
    base = n_launch;
    exp_push(8'hB0, 1'b1);
    exp_push(8'hB1, 1'b1);
    host_write(8'hB0);
    host_write(8'hB1);
    wait_launches(base + 2, 200, "timeout_launches");
    n = launch_cyc_q.size();
    if (n >= 2) chk("ack_timeout_gap", launch_cyc_q[n-1] - launch_cyc_q[n-2], 16);
    tick(20);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
